// File: rtl/lc3b_mem_unit.sv
// LC-3b memory-access sequencer: accepts word/byte/indirect load-store requests,
// drives the memory strobe port and returns a single-cycle response.
module lc3b_mem_unit #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 16,
  parameter int MAX_WAIT   = 0
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic                      req_write,
  input  logic                      req_byte,
  input  logic                      req_sext,
  input  logic                      req_indirect,
  input  logic [ADDR_WIDTH-1:0]     req_addr,
  input  logic [DATA_WIDTH-1:0]     req_wdata,
  output logic                      rsp_valid,
  output logic [DATA_WIDTH-1:0]     rsp_rdata,
  output logic                      rsp_error,
  output logic [ADDR_WIDTH-1:0]     mem_address,
  output logic                      mem_read,
  output logic                      mem_write,
  output logic [DATA_WIDTH/8-1:0]   mem_byte_enable,
  output logic [DATA_WIDTH-1:0]     mem_wdata,
  input  logic [DATA_WIDTH-1:0]     mem_rdata,
  input  logic                      mem_resp
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int LSB   = $clog2(BYTES);
  localparam int WW    = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
  localparam logic [WW:0] WAIT_LIMIT = (WW + 1)'(MAX_WAIT);

  typedef enum logic [1:0] {S_IDLE, S_PTR, S_ACCESS, S_RESP} state_t;

  state_t                  state_q, state_d;
  logic                    write_q, write_d;
  logic                    is_byte_q, is_byte_d;
  logic                    sext_q, sext_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [WW-1:0]           wait_q, wait_d;
  logic                    req_ready_q, req_ready_d;
  logic                    rsp_valid_q, rsp_valid_d;
  logic                    rsp_error_q, rsp_error_d;
  logic [DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                    mem_read_q, mem_read_d;
  logic                    mem_write_q, mem_write_d;
  logic [ADDR_WIDTH-1:0]   mem_address_q, mem_address_d;
  logic [BYTES-1:0]        mem_be_q, mem_be_d;
  logic [DATA_WIDTH-1:0]   mem_wdata_q, mem_wdata_d;

  logic                    start_acc;
  logic [ADDR_WIDTH-1:0]   acc_addr;
  logic [ADDR_WIDTH-1:0]   ptr;
  logic [7:0]              lane_byte;
  logic [LSB-1:0]          lane;
  logic [WW:0]             wait_inc;
  logic                    timeout_hit;

  always_comb begin
    state_d       = state_q;
    write_d       = write_q;
    is_byte_d     = is_byte_q;
    sext_d        = sext_q;
    wdata_d       = wdata_q;
    wait_d        = wait_q;
    rsp_valid_d   = 1'b0;
    rsp_error_d   = 1'b0;
    rsp_rdata_d   = rsp_rdata_q;
    mem_read_d    = mem_read_q;
    mem_write_d   = mem_write_q;
    mem_address_d = mem_address_q;
    mem_be_d      = mem_be_q;
    mem_wdata_d   = mem_wdata_q;
    start_acc     = 1'b0;
    acc_addr      = mem_address_q;
    ptr           = '0;
    lane          = mem_address_q[LSB-1:0];
    lane_byte     = mem_rdata[8*int'(lane) +: 8];
    wait_inc      = {1'b0, wait_q} + (WW + 1)'(1);
    timeout_hit   = (MAX_WAIT != 0) && (wait_inc == WAIT_LIMIT);

    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          write_d   = req_write;
          is_byte_d = req_byte;
          sext_d    = req_sext;
          wdata_d   = req_wdata;
          // Pointer fetches are always word reads, so they share the word alignment rule.
          if ((req_indirect || !req_byte) && (req_addr[LSB-1:0] != '0)) begin
            state_d     = S_RESP;
            rsp_valid_d = 1'b1;
            rsp_error_d = 1'b1;
          end else if (req_indirect) begin
            state_d       = S_PTR;
            mem_read_d    = 1'b1;
            mem_address_d = req_addr;
            mem_be_d      = '1;
            wait_d        = '0;
          end else begin
            start_acc = 1'b1;
            acc_addr  = req_addr;
          end
        end
      end
      S_PTR: begin
        if (mem_resp) begin
          ptr        = ADDR_WIDTH'(mem_rdata);
          mem_read_d = 1'b0;
          if (!is_byte_q && (ptr[LSB-1:0] != '0)) begin
            state_d     = S_RESP;
            rsp_valid_d = 1'b1;
            rsp_error_d = 1'b1;
          end else begin
            start_acc = 1'b1;
            acc_addr  = ptr;
          end
        end else if (timeout_hit) begin
          mem_read_d  = 1'b0;
          state_d     = S_RESP;
          rsp_valid_d = 1'b1;
          rsp_error_d = 1'b1;
        end else begin
          wait_d = wait_inc[WW-1:0];
        end
      end
      S_ACCESS: begin
        if (mem_resp) begin
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
          if (!write_q) begin
            if (is_byte_q) begin
              rsp_rdata_d = {{(DATA_WIDTH-8){sext_q & lane_byte[7]}}, lane_byte};
            end else begin
              rsp_rdata_d = mem_rdata;
            end
          end
          state_d     = S_RESP;
          rsp_valid_d = 1'b1;
        end else if (timeout_hit) begin
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
          state_d     = S_RESP;
          rsp_valid_d = 1'b1;
          rsp_error_d = 1'b1;
        end else begin
          wait_d = wait_inc[WW-1:0];
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Final access setup is shared by the direct path and the post-pointer path.
    if (start_acc) begin
      state_d       = S_ACCESS;
      mem_address_d = acc_addr;
      wait_d        = '0;
      if (write_d) begin
        mem_write_d = 1'b1;
        mem_read_d  = 1'b0;
        if (is_byte_d) begin
          mem_be_d    = BYTES'(1) << acc_addr[LSB-1:0];
          mem_wdata_d = {BYTES{wdata_d[7:0]}};
        end else begin
          mem_be_d    = '1;
          mem_wdata_d = wdata_d;
        end
      end else begin
        mem_read_d  = 1'b1;
        mem_write_d = 1'b0;
        mem_be_d    = '1;
      end
    end

    req_ready_d = (state_d == S_IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= S_IDLE;
      write_q       <= 1'b0;
      is_byte_q     <= 1'b0;
      sext_q        <= 1'b0;
      wdata_q       <= '0;
      wait_q        <= '0;
      req_ready_q   <= 1'b1;
      rsp_valid_q   <= 1'b0;
      rsp_error_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      mem_read_q    <= 1'b0;
      mem_write_q   <= 1'b0;
      mem_address_q <= '0;
      mem_be_q      <= '0;
      mem_wdata_q   <= '0;
    end else begin
      state_q       <= state_d;
      write_q       <= write_d;
      is_byte_q     <= is_byte_d;
      sext_q        <= sext_d;
      wdata_q       <= wdata_d;
      wait_q        <= wait_d;
      req_ready_q   <= req_ready_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_error_q   <= rsp_error_d;
      rsp_rdata_q   <= rsp_rdata_d;
      mem_read_q    <= mem_read_d;
      mem_write_q   <= mem_write_d;
      mem_address_q <= mem_address_d;
      mem_be_q      <= mem_be_d;
      mem_wdata_q   <= mem_wdata_d;
    end
  end

  assign req_ready       = req_ready_q;
  assign rsp_valid       = rsp_valid_q;
  assign rsp_error       = rsp_error_q;
  assign rsp_rdata       = rsp_rdata_q;
  assign mem_read        = mem_read_q;
  assign mem_write       = mem_write_q;
  assign mem_address     = mem_address_q;
  assign mem_byte_enable = mem_be_q;
  assign mem_wdata       = mem_wdata_q;

endmodule

// File: tb/tb_lc3b_mem_unit.sv
// Bench for lc3b_mem_unit: directed cases plus randomized requests against a
// transaction-level model of memory contents, phases, latency and results.
module tb_lc3b_mem_unit;

  localparam int MAXW = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic        req_byte = 1'b0;
  logic        req_sext = 1'b0;
  logic        req_indirect = 1'b0;
  logic [15:0] req_addr = '0;
  logic [15:0] req_wdata = '0;
  logic        rsp_valid;
  logic [15:0] rsp_rdata;
  logic        rsp_error;
  logic [15:0] mem_address;
  logic        mem_read;
  logic        mem_write;
  logic [1:0]  mem_byte_enable;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata = '0;
  logic        mem_resp = 1'b0;

  int checks = 0;
  int errors = 0;
  int txn_no = 0;
  logic [15:0] mem_w [0:32767];
  logic [15:0] exp_rdata = '0;

  lc3b_mem_unit #(.DATA_WIDTH(16), .ADDR_WIDTH(16), .MAX_WAIT(MAXW)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_byte(req_byte), .req_sext(req_sext), .req_indirect(req_indirect),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_error(rsp_error),
    .mem_address(mem_address), .mem_read(mem_read), .mem_write(mem_write),
    .mem_byte_enable(mem_byte_enable), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_resp(mem_resp)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int plen(input int d);
    return (d + 1 > MAXW) ? MAXW : d + 1;
  endfunction

  // One request end to end; d0/d1 are the cycles memory waits before answering
  // in the first/second strobe phase (d+1 > MAXW means memory never answers).
  task automatic run_txn(input logic w, input logic b, input logic sx, input logic ind,
                         input logic [15:0] addr, input logic [15:0] wd,
                         input int d0, input int d1);
    int exp_lat, exp_np, np, cnt, c, dd, k;
    logic exp_err, ok, got, new_phase;
    logic [15:0] fin_addr, word, ea[2], ewd[2], oa[4], owd[4];
    logic [1:0] ebe[2], obe[4];
    logic ew[2], ow[4];
    logic [7:0] bv;
    int pd[2];

    // Reference model
    pd[0] = d0; pd[1] = d1;
    exp_err = 1'b0; ok = 1'b1; exp_np = 0; exp_lat = 1; fin_addr = addr;
    if ((ind || !b) && addr[0]) begin
      exp_err = 1'b1; ok = 1'b0;
    end else if (ind) begin
      ea[0] = addr; ew[0] = 1'b0; ebe[0] = 2'b11; ewd[0] = '0;
      exp_np = 1; exp_lat += plen(d0);
      if (d0 + 1 > MAXW) begin
        exp_err = 1'b1; ok = 1'b0;
      end else begin
        fin_addr = mem_w[addr[15:1]];
        if (!b && fin_addr[0]) begin exp_err = 1'b1; ok = 1'b0; end
      end
    end
    if (ok) begin
      k = exp_np;
      dd = ind ? d1 : d0;
      ea[k] = fin_addr; ew[k] = w;
      ebe[k] = (w && b) ? (fin_addr[0] ? 2'b10 : 2'b01) : 2'b11;
      ewd[k] = b ? {wd[7:0], wd[7:0]} : wd;
      exp_np++; exp_lat += plen(dd);
      if (dd + 1 > MAXW) exp_err = 1'b1;
      else if (!w) begin
        word = mem_w[fin_addr[15:1]];
        if (b) begin
          bv = fin_addr[0] ? word[15:8] : word[7:0];
          exp_rdata = sx ? {{8{bv[7]}}, bv} : {8'h00, bv};
        end else exp_rdata = word;
      end
    end

    // Drive and observe
    check("ready_idle", req_ready, 1'b1);
    mem_resp = 1'($urandom_range(0, 1));
    mem_rdata = 16'($urandom);
    req_valid = 1'b1; req_write = w; req_byte = b; req_sext = sx;
    req_indirect = ind; req_addr = addr; req_wdata = wd;
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_write = 1'($urandom); req_byte = 1'($urandom); req_sext = 1'($urandom);
    req_indirect = 1'($urandom); req_addr = 16'($urandom); req_wdata = 16'($urandom);
    got = 1'b0; new_phase = 1'b1; np = 0; cnt = 0; c = 1;
    while (!got && c <= 24) begin
      if (rsp_valid) begin
        got = 1'b1;
        check("latency", c, exp_lat);
        check("rsp_error", rsp_error, exp_err);
        check("rsp_rdata", rsp_rdata, exp_rdata);
      end else begin
        check("ready_busy", req_ready, 1'b0);
        if (mem_read || mem_write) begin
          if (new_phase) begin
            if (np < 4) begin
              oa[np] = mem_address; ow[np] = mem_write;
              obe[np] = mem_byte_enable; owd[np] = mem_wdata;
            end
            np++; cnt = 0; new_phase = 1'b0;
          end
          cnt++;
          if (np <= 2 && cnt == pd[np-1] + 1) begin
            mem_resp = 1'b1;
            mem_rdata = mem_read ? mem_w[mem_address[15:1]] : 16'($urandom);
            new_phase = 1'b1;
          end else begin
            mem_resp = 1'b0;
            mem_rdata = 16'($urandom);
          end
        end else begin
          new_phase = 1'b1;
          mem_resp = 1'($urandom_range(0, 1));
          mem_rdata = 16'($urandom);
        end
        @(posedge clk); #1;
        c++;
      end
    end
    if (!got) check("rsp_arrived", 1'b0, 1'b1);
    check("phase_count", np, exp_np);
    for (int i = 0; i < 2; i++) begin
      if (i < np && i < exp_np) begin
        check("phase_addr", oa[i], ea[i]);
        check("phase_write", ow[i], ew[i]);
        check("phase_be", obe[i], ebe[i]);
        if (ew[i]) check("phase_wdata", owd[i], ewd[i]);
      end
    end
    if (w && !exp_err) begin
      if (!b) mem_w[fin_addr[15:1]] = wd;
      else if (fin_addr[0]) mem_w[fin_addr[15:1]][15:8] = wd[7:0];
      else mem_w[fin_addr[15:1]][7:0] = wd[7:0];
    end
    $display("txn %0d w=%0b b=%0b sx=%0b ind=%0b addr=%h wd=%h d=%0d/%0d lat=%0d err=%0b rdata=%h",
             txn_no, w, b, sx, ind, addr, wd, d0, d1, c, rsp_error, rsp_rdata);
    txn_no++;
    mem_resp = 1'b0;
    @(posedge clk); #1;
    check("rsp_pulse_one", rsp_valid, 1'b0);
  endtask

  function automatic int rand_delay();
    int r;
    r = $urandom_range(0, 9);
    if (r < 6) return r % 3;
    if (r < 8) return 3;
    return 6;
  endfunction

  initial begin
    logic [15:0] a;
    for (int i = 0; i < 32768; i++) mem_w[i] = 16'($urandom);

    #2 reset_n = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    check("rst_ready", req_ready, 1'b1);
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_rsp_error", rsp_error, 1'b0);
    check("rst_rsp_rdata", rsp_rdata, 16'h0000);
    check("rst_mem_rw", {mem_read, mem_write}, 2'b00);
    check("rst_mem_addr", mem_address, 16'h0000);
    check("rst_mem_be", mem_byte_enable, 2'b00);
    check("rst_mem_wdata", mem_wdata, 16'h0000);
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk); #1;

    mem_w[16'h0040 >> 1] = 16'hBEEF;
    run_txn(1'b0, 1'b0, 1'b0, 1'b0, 16'h0040, 16'h0000, 0, 0);
    check("plan_word_load", rsp_rdata, 16'hBEEF);
    mem_w[16'h0040 >> 1] = 16'h80AA;
    run_txn(1'b0, 1'b1, 1'b1, 1'b0, 16'h0041, 16'h0000, 0, 0);
    check("plan_byte_sext", rsp_rdata, 16'hFF80);
    run_txn(1'b0, 1'b1, 1'b0, 1'b0, 16'h0041, 16'h0000, 1, 0);
    check("plan_byte_zext", rsp_rdata, 16'h0080);
    run_txn(1'b1, 1'b1, 1'b0, 1'b0, 16'h0043, 16'h1234, 0, 0);
    mem_w[16'h0010 >> 1] = 16'h2000;
    mem_w[16'h2000 >> 1] = 16'h5A5A;
    run_txn(1'b0, 1'b0, 1'b0, 1'b1, 16'h0010, 16'h0000, 0, 0);
    check("plan_indirect", rsp_rdata, 16'h5A5A);
    run_txn(1'b0, 1'b0, 1'b0, 1'b0, 16'h0021, 16'h0000, 0, 0);
    run_txn(1'b0, 1'b0, 1'b0, 1'b0, 16'h0080, 16'h0000, 9, 0);
    check("plan_timeout_rdata", rsp_rdata, 16'h5A5A);
    run_txn(1'b1, 1'b0, 1'b0, 1'b0, 16'h0082, 16'hCAFE, 3, 0);

    // Reset in the middle of a strobe phase
    req_valid = 1'b1; req_write = 1'b0; req_byte = 1'b0; req_indirect = 1'b0;
    req_addr = 16'h0100;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("mid_strobe_up", mem_read, 1'b1);
    @(posedge clk); #3;
    reset_n = 1'b0;
    #1;
    check("mid_rst_rw", {mem_read, mem_write}, 2'b00);
    check("mid_rst_ready", req_ready, 1'b1);
    check("mid_rst_addr", mem_address, 16'h0000);
    check("mid_rst_rdata", rsp_rdata, 16'h0000);
    exp_rdata = '0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("mid_rst_no_rsp", rsp_valid, 1'b0);
    end
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_no_rsp", rsp_valid, 1'b0);
    run_txn(1'b0, 1'b0, 1'b0, 1'b0, 16'h2000, 16'h0000, 0, 0);

    for (int t = 0; t < 160; t++) begin
      a = 16'($urandom);
      if ($urandom_range(0, 3) != 0) a[0] = 1'b0;
      if (t % 5 == 0) a = {11'h0, a[4:0]};
      run_txn(1'($urandom), 1'($urandom), 1'($urandom), ($urandom_range(0, 2) == 0),
              a, 16'($urandom), rand_delay(), rand_delay());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout observed running expected finished");
    $fatal(1, "simulation time limit");
  end

endmodule
